// File: rtl/clz_shift_left.sv
// Registered count-leading-zeros plus left shift by the count or by an external amount.
// Define CLZ_SHIFT_LEFT_INPUT_REG_EN to add an input register stage (latency 2 instead of 1).
module clz_shift_left #(
    parameter int WIDTH = 8,
    parameter int SHIFT_VAL_WIDTH = $clog2(WIDTH) + 1,
    localparam int CNT_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_normalize,
    input  logic [SHIFT_VAL_WIDTH-1:0] in_shift,
    output logic                       out_valid,
    output logic [CNT_WIDTH-1:0]       out_clz,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_zero
);
    localparam int STAGES = $clog2(WIDTH);
    localparam int AMT_WIDTH = (SHIFT_VAL_WIDTH > CNT_WIDTH) ? SHIFT_VAL_WIDTH : CNT_WIDTH;

    logic                       stValid;
    logic [WIDTH-1:0]           stData;
    logic                       stNorm;
    logic [SHIFT_VAL_WIDTH-1:0] stShift;

`ifdef CLZ_SHIFT_LEFT_INPUT_REG_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stValid <= 1'b0;
            stData  <= '0;
            stNorm  <= 1'b0;
            stShift <= '0;
        end else begin
            stValid <= in_valid;
            if (in_valid) begin
                stData  <= in_data;
                stNorm  <= in_normalize;
                stShift <= in_shift;
            end
        end
    end
`else
    assign stValid = in_valid;
    assign stData  = in_data;
    assign stNorm  = in_normalize;
    assign stShift = in_shift;
`endif

    logic [CNT_WIDTH-1:0] clzVal;
    logic                 isZero;

    // Scanning upward lets the highest set bit overwrite any lower one.
    always_comb begin
        clzVal = CNT_WIDTH'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (stData[i]) begin
                clzVal = CNT_WIDTH'(WIDTH - 1 - i);
            end
        end
    end

    assign isZero = ~|stData;

    logic [AMT_WIDTH-1:0] shiftAmt;
    logic [WIDTH-1:0]     shiftStage [STAGES+1];
    logic                 overflow;
    logic [WIDTH-1:0]     shifted;

    assign shiftAmt = stNorm ? AMT_WIDTH'(clzVal) : AMT_WIDTH'(stShift);
    assign shiftStage[0] = stData;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : gBarrel
            assign shiftStage[gi+1] = shiftAmt[gi] ? (shiftStage[gi] << (2 ** gi)) : shiftStage[gi];
        end
        // Any set bit above the barrel stages means the word is shifted out entirely.
        if (AMT_WIDTH > STAGES) begin : gOverflow
            assign overflow = |shiftAmt[AMT_WIDTH-1:STAGES];
        end else begin : gNoOverflow
            assign overflow = 1'b0;
        end
    endgenerate

    assign shifted = overflow ? '0 : shiftStage[STAGES];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_clz   <= '0;
            out_data  <= '0;
            out_zero  <= 1'b0;
        end else begin
            out_valid <= stValid;
            if (stValid) begin
                out_clz  <= clzVal;
                out_data <= shifted;
                out_zero <= isZero;
            end
        end
    end
endmodule

// File: tb/tb_clz_shift_left.sv
// Scoreboard bench for clz_shift_left: stimulus pushes expected results, a negedge monitor pops and compares.
module tb_clz_shift_left;
`ifdef CLZ_SHIFT_LEFT_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_normalize = 1'b0;
    logic [3:0] in_shift = 4'd0;
    logic       out_valid;
    logic [3:0] out_clz;
    logic [7:0] out_data;
    logic       out_zero;

    clz_shift_left #(.WIDTH(8)) dut (
        .clock(clock),
        .resetn(resetn),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_normalize(in_normalize),
        .in_shift(in_shift),
        .out_valid(out_valid),
        .out_clz(out_clz),
        .out_data(out_data),
        .out_zero(out_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         due;
        logic [3:0] clz;
        logic [7:0] data;
        logic       zero;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (resetn && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("latency", cyc, e.due);
                check("out_clz", int'(out_clz), int'(e.clz));
                check("out_data", int'(out_data), int'(e.data));
                check("out_zero", int'(out_zero), int'(e.zero));
                $display("txn %0d: cycle %0d clz=%0d data=%02h zero=%0b", txn, cyc, out_clz, out_data, out_zero);
                txn++;
            end
        end
    end

    // Called at a negedge; returns at the next negedge.
    task automatic send(input logic v, input logic [7:0] d, input logic norm, input logic [3:0] sh,
                        input logic [3:0] eClz, input logic [7:0] eData, input logic eZero);
        exp_t e;
        in_valid = v;
        in_data = d;
        in_normalize = norm;
        in_shift = sh;
        if (v) begin
            e.due = cyc + LAT;
            e.clz = eClz;
            e.data = eData;
            e.zero = eZero;
            sb.push_back(e);
        end
        @(negedge clock);
    endtask

    initial begin
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_clz", int'(out_clz), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_zero", int'(out_zero), 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        send(1, 8'h16, 1, 4'd0, 4'd3, 8'hB0, 0);
        send(1, 8'h00, 1, 4'd0, 4'd8, 8'h00, 1);
        send(1, 8'h80, 1, 4'd0, 4'd0, 8'h80, 0);
        send(1, 8'hFF, 0, 4'd5, 4'd0, 8'hE0, 0);
        send(1, 8'hFF, 0, 4'd8, 4'd0, 8'h00, 0);
        send(1, 8'hFF, 0, 4'd15, 4'd0, 8'h00, 0);
        send(1, 8'h01, 1, 4'd0, 4'd7, 8'h80, 0);
        send(1, 8'h40, 1, 4'd0, 4'd1, 8'h80, 0);
        send(1, 8'h03, 1, 4'd0, 4'd6, 8'hC0, 0);
        send(1, 8'h00, 0, 4'd3, 4'd8, 8'h00, 1);
        send(1, 8'h16, 0, 4'd2, 4'd3, 8'h58, 0);

        // Idle with wiggling inputs: outputs must hold the last result.
        send(0, 8'hAA, 1, 4'd1, 4'd0, 8'h00, 0);
        send(0, 8'h55, 0, 4'd7, 4'd0, 8'h00, 0);
        send(0, 8'h0F, 1, 4'd2, 4'd0, 8'h00, 0);
        check("idle_valid", int'(out_valid), 0);
        check("idle_data_hold", int'(out_data), 8'h58);
        check("idle_clz_hold", int'(out_clz), 3);

        // Stream, then assert reset mid-cycle while valid words are in flight.
        send(1, 8'h00, 1, 4'd0, 4'd8, 8'h00, 1);
        send(1, 8'h00, 1, 4'd0, 4'd8, 8'h00, 1);
        in_valid = 1'b1;
        in_data = 8'h16;
        in_normalize = 1'b1;
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_clz", int'(out_clz), 0);
        check("async_rst_data", int'(out_data), 0);
        check("async_rst_zero", int'(out_zero), 0);
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            in_data = 8'h21 + 8'(i);
            check("rst_hold_valid", int'(out_valid), 0);
            check("rst_hold_data", int'(out_data), 0);
        end
        @(negedge clock);
        resetn = 1'b1;
        send(1, 8'h16, 1, 4'd0, 4'd3, 8'hB0, 0);
        send(1, 8'h20, 0, 4'd1, 4'd2, 8'h40, 0);
        send(0, 8'h00, 0, 4'd0, 4'd0, 8'h00, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/clz_shift_left.md
# clz_shift_left

Registered normalization block: counts the leading zeros of a WIDTH-bit word and left-shifts the word either by that count or by an externally supplied amount. Used by posit/float decode and normalize paths, e.g. regime-length extraction (CLZ of neighbour-XOR bits) and alignment of exponent/fraction bits. It is a valid-qualified, single-issue pipeline with no backpressure.

## Interface
- WIDTH, 8: data width in bits, ≥ 2.
- SHIFT_VAL_WIDTH, $clog2(WIDTH)+1: width of the external shift amount.
- CNT_WIDTH, $clog2(WIDTH+1): width of the leading-zero count. Derived; must not be overridden.
- clock  input  1  rising-edge clock.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  when high, the input word is accepted this cycle.
- in_data  input  WIDTH  word to analyse and shift.
- in_normalize  input  1  1: shift by the leading-zero count; 0: shift by in_shift.
- in_shift  input  SHIFT_VAL_WIDTH  external left-shift amount, unsigned.
- out_valid  output  1  result valid.
- out_clz  output  CNT_WIDTH  leading zeros of the accepted in_data.
- out_data  output  WIDTH  shifted word.
- out_zero  output  1  the accepted in_data was all zeros.

## Operation
- CLZ counts zero bits from the MSB (bit WIDTH-1) down to the first 1.
  - All-zero input gives out_clz = WIDTH and out_zero = 1.
  - Otherwise out_zero = 0 and out_clz < WIDTH.
  - Structure: priority or tree encoder; any structure is acceptable if bit-exact.
- Shift amount s:
  - s = out_clz when in_normalize = 1.
  - s = in_shift otherwise.
- out_data = in_data << s, logical shift with zero fill.
  - Any s ≥ WIDTH gives out_data = 0. Amounts must not wrap modulo WIDTH.
  - Structure: log2 barrel shifter with an overflow detect on the upper shift bits.
- Normalize mode on a non-zero input always leaves out_data[WIDTH-1] = 1.
- Normalize mode on a zero input gives out_data = 0.
- out_clz and out_zero are computed in both modes.
- in_normalize and in_shift are ignored when in_valid = 0.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N, and out_valid is high for that one cycle.
- Throughput is 1 word per cycle; back-to-back valids produce back-to-back results.
- out_valid is registered from in_valid every cycle.
- Data registers (out_clz, out_data, out_zero) load only when in_valid = 1; otherwise they hold their last value.
- Reset (resetn = 0, asynchronous) forces:
  - out_valid = 0, out_clz = 0, out_data = 0, out_zero = 0.
  - These values hold immediately and while reset is low.
  - A word in flight during reset is discarded.
- Release of resetn is synchronous to clock; the first capture happens on the first edge after release.

## Configuration
- Macro CLZ_SHIFT_LEFT_INPUT_REG_EN.
- Defined: adds an input register stage (in_valid, in_data, in_normalize, in_shift) before the CLZ/shift logic.
  - Latency becomes 2 cycles; throughput is unchanged.
  - The added stage resets the same way (valid = 0, data = 0).
- Undefined: latency is 1 cycle as described above.

## Test plan
- WIDTH=8, normalize, in_data=8'b0001_0110 → next cycle: out_clz=3, out_data=8'b1011_0000, out_zero=0, out_valid=1.
- Normalize, in_data=8'h00 → out_clz=8, out_data=8'h00, out_zero=1. Also in_data=8'h80 → out_clz=0, out_data=8'h80.
- External shift, in_data=8'hFF:
  - in_shift=5 → out_data=8'hE0.
  - in_shift=8 → 8'h00.
  - in_shift=15 → 8'h00.
  - out_clz=0 in all three.
- Back-to-back valids 8'h01, 8'h40, 8'h03 (normalize) → consecutive out_clz 7, 1, 6 and out_data 8'h80, 8'h80, 8'hC0.
- Reset asserted mid-stream with in_valid=1 → out_valid and all outputs 0 without waiting for a clock edge. The first result appears one cycle after the first valid following release.
- Idle cycle (in_valid=0, in_data changing) → out_valid=0 and out_data holds its previous value. Repeat with CLZ_SHIFT_LEFT_INPUT_REG_EN defined and check 2-cycle latency.
